// File: rtl/uart_alu_frame_ctrl_if.sv
// Byte-stream and result bus between uart_alu_frame_ctrl and the UART / LED logic.
// master: the frame controller; slave: the UART receiver/transmitter side.
interface uart_alu_frame_ctrl_if #(
  parameter int N_BITS  = 8,
  parameter int NB_DATA = 16
);
  logic                i_rx_valid;
  logic [N_BITS-1:0]   i_rx_data;
  logic                i_tx_done;
  logic                o_tx_start;
  logic [N_BITS-1:0]   o_tx_data;
  logic [NB_DATA-1:0]  o_result;
  logic [3:0]          o_status;
  logic                o_busy;
  logic                o_err;

  modport master (
    input  i_rx_valid, i_rx_data, i_tx_done,
    output o_tx_start, o_tx_data, o_result, o_status, o_busy, o_err
  );

  modport slave (
    output i_rx_valid, i_rx_data, i_tx_done,
    input  o_tx_start, o_tx_data, o_result, o_status, o_busy, o_err
  );
endinterface

// File: rtl/uart_alu_frame_ctrl.sv
// UART frame assembler + ALU + response streamer with inter-byte timeout.
// Define UART_ALU_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module uart_alu_frame_ctrl #(
  parameter int N_BITS         = 8,
  parameter int NB_DATA        = 16,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  uart_alu_frame_ctrl_if.master bus
);
  localparam int NBYTES     = NB_DATA / N_BITS;
  localparam int DATA_BYTES = 2 * NBYTES + 1;
`ifdef UART_ALU_CHECKSUM_EN
  localparam int FRAME_BYTES = DATA_BYTES + 1;
`else
  localparam int FRAME_BYTES = DATA_BYTES;
`endif
  localparam int CNT_W = $clog2(FRAME_BYTES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TX_W  = $clog2(NBYTES + 2);
  localparam int MSB   = NB_DATA - 1;

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  typedef enum logic [2:0] {IDLE, RX, EXEC, TX_LOAD, TX_WAIT} state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             byte_cnt_q;
  logic [TMO_W-1:0]             tmo_cnt_q;
  logic [TX_W-1:0]              tx_idx_q;
  logic [DATA_BYTES*N_BITS-1:0] frame_q;
  logic [NB_DATA-1:0]           result_q;
  logic [3:0]                   status_q;
  logic [N_BITS-1:0]            tx_data_q;
  logic                         tx_start_q;
  logic                         err_q, err_d;

  logic                         tmo_hit, last_byte, csum_ok;
  logic [NB_DATA-1:0]           op_a, op_b, alu_result;
  logic [NB_OP-1:0]             opcode;
  logic                         carry, ovf, invalid;
  logic [3:0]                   alu_status;
  logic [(NBYTES+1)*N_BITS-1:0] resp_word;
  logic [N_BITS-1:0]            resp_byte;
  logic                         op_byte_unused;

  assign op_a           = frame_q[0 +: NB_DATA];
  assign op_b           = frame_q[NB_DATA +: NB_DATA];
  assign opcode         = frame_q[2*NB_DATA +: NB_OP];
  assign op_byte_unused = ^frame_q[2*NB_DATA +: N_BITS];

  assign tmo_hit   = (state_q == RX) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign last_byte = (state_q == RX) && bus.i_rx_valid && !tmo_hit &&
                     (byte_cnt_q == CNT_W'(FRAME_BYTES - 1));

`ifdef UART_ALU_CHECKSUM_EN
  logic [N_BITS-1:0] csum;
  always_comb begin
    csum = bus.i_rx_data;
    for (int unsigned i = 0; i < unsigned'(DATA_BYTES); i++) begin
      csum = csum ^ frame_q[i*N_BITS +: N_BITS];
    end
  end
  assign csum_ok = (csum == '0);
`else
  assign csum_ok = 1'b1;
`endif

  always_comb begin
    alu_result = '0;
    carry      = 1'b0;
    ovf        = 1'b0;
    invalid    = 1'b0;
    case (opcode)
      OP_ADD: begin
        {carry, alu_result} = {1'b0, op_a} + {1'b0, op_b};
        ovf = (op_a[MSB] == op_b[MSB]) && (alu_result[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        alu_result = op_a - op_b;
        carry      = (op_a < op_b);
        ovf        = (op_a[MSB] != op_b[MSB]) && (alu_result[MSB] != op_a[MSB]);
      end
      OP_AND: alu_result = op_a & op_b;
      OP_OR:  alu_result = op_a | op_b;
      OP_XOR: alu_result = op_a ^ op_b;
      OP_NOR: alu_result = ~(op_a | op_b);
      OP_SRA: begin
        if (op_b >= NB_DATA'(NB_DATA)) alu_result = {NB_DATA{op_a[MSB]}};
        else                           alu_result = $unsigned($signed(op_a) >>> op_b);
      end
      OP_SRL: begin
        if (op_b >= NB_DATA'(NB_DATA)) alu_result = '0;
        else                           alu_result = op_a >> op_b;
      end
      default: invalid = 1'b1;
    endcase
    alu_status = {invalid, ovf, (!invalid && (alu_result == '0)), carry};
  end

  assign resp_word = {N_BITS'(status_q), result_q};
  assign resp_byte = resp_word[tx_idx_q*N_BITS +: N_BITS];

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (bus.i_rx_valid) state_d = RX;
      RX: begin
        if (tmo_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (last_byte) begin
          if (csum_ok) begin
            state_d = EXEC;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      EXEC:    state_d = TX_LOAD;
      TX_LOAD: state_d = TX_WAIT;
      TX_WAIT: begin
        if (bus.i_tx_done) state_d = (tx_idx_q == TX_W'(NBYTES)) ? IDLE : TX_LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      tx_idx_q   <= '0;
      frame_q    <= '0;
      result_q   <= '0;
      status_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tmo_cnt_q  <= '0;
          tx_idx_q   <= '0;
          byte_cnt_q <= '0;
          if (bus.i_rx_valid) begin
            frame_q[0 +: N_BITS] <= bus.i_rx_data;
            byte_cnt_q           <= CNT_W'(1);
          end
        end
        RX: begin
          if (tmo_hit) begin
            byte_cnt_q <= '0;
            tmo_cnt_q  <= '0;
          end else if (bus.i_rx_valid) begin
            // The checksum byte is only compared on arrival, never stored.
            if (byte_cnt_q < CNT_W'(DATA_BYTES))
              frame_q[byte_cnt_q*N_BITS +: N_BITS] <= bus.i_rx_data;
            byte_cnt_q <= byte_cnt_q + 1'b1;
            tmo_cnt_q  <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        // EXEC launches the first response byte itself so it appears in the
        // following TX_LOAD cycle; later bytes are launched out of TX_LOAD,
        // giving a two-cycle i_tx_done -> o_tx_start spacing.
        EXEC: begin
          result_q   <= alu_result;
          status_q   <= alu_status;
          tx_data_q  <= alu_result[N_BITS-1:0];
          tx_start_q <= 1'b1;
          tx_idx_q   <= '0;
          byte_cnt_q <= '0;
        end
        TX_LOAD: begin
          if (tx_idx_q != '0) begin
            tx_data_q  <= resp_byte;
            tx_start_q <= 1'b1;
          end
        end
        TX_WAIT: if (bus.i_tx_done) tx_idx_q <= tx_idx_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.o_tx_start = tx_start_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_result   = result_q;
  assign bus.o_status   = status_q;
  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_err      = err_q;
endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Self-checking bench for uart_alu_frame_ctrl: spec vectors, random ops against an
// integer reference model, timeout, dropped bytes, reset abort and checksum cases.
module tb_uart_alu_frame_ctrl;
  localparam int NB     = 16;
  localparam int NBYTES = NB / 8;
  localparam int TMO    = 40;
`ifdef UART_ALU_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int unsigned n_cmp, n_bad;
  int unsigned start_cnt, err_cnt;
  logic [NB-1:0] last_res;
  logic [3:0]    last_st;

  uart_alu_frame_ctrl_if #(.N_BITS(8), .NB_DATA(NB)) bus ();

  uart_alu_frame_ctrl #(
    .N_BITS(8), .NB_DATA(NB), .NB_OP(6), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.o_tx_start === 1'b1) start_cnt++;
    if (bus.o_err === 1'b1) err_cnt++;
  end

  typedef struct {
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic [7:0]    op;
    logic [NB-1:0] r;
    logic [3:0]    st;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    step();
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'($urandom);
  endtask

  task automatic pulse_done();
    bus.i_tx_done = 1'b1;
    step();
    bus.i_tx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic [7:0] op,
                            input int unsigned gap, input bit bad_csum);
    logic [7:0] q[$];
    logic [7:0] cs;
    for (int i = 0; i < NBYTES; i++) q.push_back(a[i*8 +: 8]);
    for (int i = 0; i < NBYTES; i++) q.push_back(b[i*8 +: 8]);
    q.push_back(op);
    cs = '0;
    foreach (q[i]) cs = cs ^ q[i];
    if (CHK) q.push_back(bad_csum ? ~cs : cs);
    foreach (q[i]) begin
      if (i != 0) repeat (gap) step();
      send_byte(q[i]);
    end
  endtask

  // Reference: integer arithmetic on signed/unsigned interpretations of A and B.
  function automatic void model(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic [7:0] opb,
                                output logic [NB-1:0] r, output logic [3:0] st);
    longint ua, ub, sa, sb, t, full, half;
    logic c, v, inv;
    full = longint'(1) << NB;
    half = longint'(1) << (NB - 1);
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    c = 1'b0; v = 1'b0; inv = 1'b0; t = 0;
    case (opb[5:0])
      6'h20: begin t = ua + ub; c = (t >= full); v = (sa + sb >= half) || (sa + sb < -half); end
      6'h22: begin t = ua - ub; c = (ua < ub);   v = (sa - sb >= half) || (sa - sb < -half); end
      6'h24: t = ua & ub;
      6'h25: t = ua | ub;
      6'h26: t = ua ^ ub;
      6'h27: t = ~(ua | ub);
      6'h03: t = (ub >= NB) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
      6'h02: t = (ub >= NB) ? 0 : (ua >> ub);
      default: inv = 1'b1;
    endcase
    r  = t[NB-1:0];
    st = {inv, v, (!inv && (r == 0)), c};
  endfunction

  task automatic run_txn(input string nm, input logic [NB-1:0] a, input logic [NB-1:0] b,
                         input logic [7:0] op, input logic [NB-1:0] er, input logic [3:0] es,
                         input int unsigned gap, input bit noise);
    logic [7:0] eb, d;
    int unsigned s0;
    s0 = start_cnt;
    send_frame(a, b, op, gap, 1'b0);
    check({nm, " exec_no_start"}, bus.o_tx_start, 1'b0);
    check({nm, " exec_busy"}, bus.o_busy, 1'b1);
    if (noise) begin
      bus.i_tx_done  = 1'b1;
      bus.i_rx_valid = 1'b1;
    end
    step();
    bus.i_tx_done  = 1'b0;
    bus.i_rx_valid = 1'b0;
    check({nm, " first_start"}, bus.o_tx_start, 1'b1);
    check({nm, " result"}, bus.o_result, er);
    check({nm, " status"}, bus.o_status, es);
    for (int k = 0; k <= NBYTES; k++) begin
      eb = (k < NBYTES) ? er[k*8 +: 8] : {4'b0, es};
      check({nm, " tx_byte"}, bus.o_tx_data, eb);
      d = bus.o_tx_data;
      repeat ($urandom_range(1, 3)) begin
        if (noise) begin
          bus.i_rx_valid = 1'($urandom);
          bus.i_rx_data  = 8'($urandom);
        end
        step();
        check({nm, " no_restart"}, bus.o_tx_start, 1'b0);
        check({nm, " data_held"}, bus.o_tx_data, d);
      end
      bus.i_rx_valid = 1'b0;
      pulse_done();
      if (k < NBYTES) begin
        check({nm, " load_gap"}, bus.o_tx_start, 1'b0);
        if (noise) bus.i_tx_done = 1'b1;
        step();
        bus.i_tx_done = 1'b0;
        check({nm, " next_start"}, bus.o_tx_start, 1'b1);
      end else begin
        check({nm, " idle_after"}, bus.o_busy, 1'b0);
      end
    end
    step();
    check({nm, " start_count"}, start_cnt - s0, NBYTES + 1);
    last_res = er;
    last_st  = es;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[17];
    logic [NB-1:0] a, b, er;
    logic [7:0]    opb;
    logic [3:0]    es;
    logic [7:0]    ops[8];
    int unsigned   s0, e0;

    vecs[0]  = '{16'h1234, 16'h0F0F, 8'h20, 16'h2143, 4'h0};
    vecs[1]  = '{16'h0000, 16'h0001, 8'h22, 16'hFFFF, 4'h1};
    vecs[2]  = '{16'h7FFF, 16'h0001, 8'h20, 16'h8000, 4'h4};
    vecs[3]  = '{16'h8000, 16'h0014, 8'h03, 16'hFFFF, 4'h0};
    vecs[4]  = '{16'h1234, 16'h5678, 8'h3F, 16'h0000, 4'h8};
    vecs[5]  = '{16'hFFFF, 16'h0001, 8'h20, 16'h0000, 4'h3};
    vecs[6]  = '{16'h8000, 16'h0001, 8'h22, 16'h7FFF, 4'h4};
    vecs[7]  = '{16'hF0F0, 16'h0FF0, 8'h24, 16'h00F0, 4'h0};
    vecs[8]  = '{16'hF0F0, 16'h0F0F, 8'h25, 16'hFFFF, 4'h0};
    vecs[9]  = '{16'hAAAA, 16'hAAAA, 8'h26, 16'h0000, 4'h2};
    vecs[10] = '{16'h0000, 16'h0000, 8'h27, 16'hFFFF, 4'h0};
    vecs[11] = '{16'h8000, 16'h000F, 8'h02, 16'h0001, 4'h0};
    vecs[12] = '{16'h8000, 16'h0010, 8'h02, 16'h0000, 4'h2};
    vecs[13] = '{16'h8000, 16'h000F, 8'h03, 16'hFFFF, 4'h0};
    vecs[14] = '{16'h1234, 16'h0004, 8'h03, 16'h0123, 4'h0};
    vecs[15] = '{16'h0001, 16'h0001, 8'hE0, 16'h0002, 4'h0};
    vecs[16] = '{16'h0005, 16'h0005, 8'h22, 16'h0000, 4'h2};
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

    n_cmp = 0; n_bad = 0; start_cnt = 0; err_cnt = 0;
    last_res = '0; last_st = '0;
    bus.i_rx_valid = 1'b0; bus.i_rx_data = '0; bus.i_tx_done = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    check("rst tx_start", bus.o_tx_start, 1'b0);
    check("rst tx_data", bus.o_tx_data, 8'h00);
    check("rst result", bus.o_result, 16'h0000);
    check("rst status", bus.o_status, 4'h0);
    check("rst busy", bus.o_busy, 1'b0);
    check("rst err", bus.o_err, 1'b0);
    rst_n = 1'b1;
    step();

    // i_tx_done while idle must not start anything
    pulse_done();
    pulse_done();
    check("done_in_idle busy", bus.o_busy, 1'b0);
    check("done_in_idle start", start_cnt, 0);

    foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                              vecs[i].r, vecs[i].st, 0, i[0]);

    // Timeout: two bytes then silence; a byte on the expiring cycle is dropped.
    s0 = start_cnt;
    e0 = err_cnt;
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TMO - 1) step();
    check("tmo before err", bus.o_err, 1'b0);
    check("tmo before busy", bus.o_busy, 1'b1);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = 8'h99;
    step();
    bus.i_rx_valid = 1'b0;
    check("tmo err pulse", bus.o_err, 1'b1);
    check("tmo idle", bus.o_busy, 1'b0);
    step();
    check("tmo err one cycle", bus.o_err, 1'b0);
    check("tmo byte dropped", bus.o_busy, 1'b0);
    repeat (3) step();
    check("tmo err count", err_cnt - e0, 1);
    check("tmo no tx", start_cnt - s0, 0);
    check("tmo result kept", bus.o_result, last_res);
    run_txn("after_tmo", vecs[0].a, vecs[0].b, vecs[0].op, vecs[0].r, vecs[0].st, 0, 1'b0);
    // Longest gap that still keeps the frame alive
    run_txn("max_gap", vecs[2].a, vecs[2].b, vecs[2].op, vecs[2].r, vecs[2].st, TMO - 2, 1'b0);

`ifdef UART_ALU_CHECKSUM_EN
    s0 = start_cnt;
    e0 = err_cnt;
    send_frame(16'h1234, 16'h0F0F, 8'h20, 0, 1'b1);
    check("csum err pulse", bus.o_err, 1'b1);
    check("csum idle", bus.o_busy, 1'b0);
    step();
    check("csum err one cycle", bus.o_err, 1'b0);
    repeat (5) step();
    check("csum no tx", start_cnt - s0, 0);
    check("csum err count", err_cnt - e0, 1);
    check("csum result kept", bus.o_result, last_res);
    check("csum status kept", bus.o_status, last_st);
    run_txn("csum_ok", vecs[0].a, vecs[0].b, vecs[0].op, vecs[0].r, vecs[0].st, 0, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      opb = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) opb = 8'($urandom);
      if ((opb[5:0] == 6'h02 || opb[5:0] == 6'h03) && $urandom_range(0, 3) != 0)
        b = 16'($urandom_range(0, 20));
      opb[7:6] = 2'($urandom);
      model(a, b, opb, er, es);
      run_txn($sformatf("rand%0d", n), a, b, opb, er, es, $urandom_range(0, 3), 1'($urandom));
    end

    // Reset after the first response byte: everything clears, nothing more is sent.
    send_frame(16'h1111, 16'h2222, 8'h20, 0, 1'b0);
    step();
    check("rstmid first start", bus.o_tx_start, 1'b1);
    repeat (2) step();
    pulse_done();
    send_byte(8'h55);
    check("rstmid second start", bus.o_tx_start, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstmid tx_start", bus.o_tx_start, 1'b0);
    check("rstmid tx_data", bus.o_tx_data, 8'h00);
    check("rstmid result", bus.o_result, 16'h0000);
    check("rstmid status", bus.o_status, 4'h0);
    check("rstmid busy", bus.o_busy, 1'b0);
    check("rstmid err", bus.o_err, 1'b0);
    s0 = start_cnt;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();
    check("rstmid no more tx", start_cnt - s0, 0);
    check("rstmid idle", bus.o_busy, 1'b0);
    run_txn("after_rst", vecs[1].a, vecs[1].b, vecs[1].op, vecs[1].r, vecs[1].st, 1, 1'b1);

    check("total err pulses", err_cnt, 1 + (CHK ? 1 : 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
